acc_writeback: RTL and testbench

//  Drain controller on the read side of the ACC psum FIFOs.
//  On start, pops FIFO_DEPTH result rows from ACC (drives ACC rden_i) and captures each row.

---
 rtl/acc_writeback.sv | 118 +++++++++++
 tb/tb_acc_writeback.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_writeback.sv
// acc_writeback: drains FIFO_DEPTH rows from the ACC psum FIFOs into consecutive GLB words.
// Optional build macro ACC_WB_RELU_EN clamps negative lanes to zero on capture.
module acc_writeback #(
    parameter int PE_SIZE    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    output logic [PE_SIZE-1:0]               rden_o,
    input  logic [DATA_WIDTH*PE_SIZE-1:0]    psum_row_i,
    output logic                             glb_wren_o,
    input  logic                             glb_ready_i,
    output logic [ADDR_WIDTH-1:0]            glb_addr_o,
    output logic [DATA_WIDTH*PE_SIZE-1:0]    glb_data_o,
    output logic                             busy_o,
    output logic                             done_o
);

    localparam int ROW_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        WRITE,
        DONE
    } state_t;

    state_t                          state_q;
    state_t                          state_d;
    logic [ROW_W-1:0]                row_q;
    logic [ADDR_WIDTH-1:0]           base_q;
    logic [DATA_WIDTH*PE_SIZE-1:0]   row_capt;
    logic                            row_is_last;
    logic                            accept;

    assign row_is_last = (row_q == ROW_W'(FIFO_DEPTH - 1));
    assign accept      = (state_q == WRITE) && glb_ready_i;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = READ;
            READ:    state_d = CAPT;
            CAPT:    state_d = WRITE;
            WRITE:   if (glb_ready_i) state_d = row_is_last ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rden_o     = {PE_SIZE{state_q == READ}};
        glb_wren_o = (state_q == WRITE);
        busy_o     = (state_q != IDLE);
        done_o     = (state_q == DONE);
    end

    // Lane clamp is pure combinational on the capture path, so both builds share timing.
    always_comb begin
        row_capt = psum_row_i;
`ifdef ACC_WB_RELU_EN
        for (int l = 0; l < PE_SIZE; l++) begin
            if (psum_row_i[l*DATA_WIDTH + DATA_WIDTH - 1]) begin
                row_capt[l*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`else
`endif
    end

    // NOTE: the address/data registers are plain flops (not a memory), so they
    // are reset to give the deterministic all-zero outputs seen after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            row_q      <= '0;
            glb_addr_o <= '0;
            glb_data_o <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q <= base_addr_i;
                        row_q  <= '0;
                    end
                end
                CAPT: begin
                    glb_data_o <= row_capt;
                    glb_addr_o <= base_q + ADDR_WIDTH'(row_q);
                end
                WRITE: begin
                    if (accept && !row_is_last) begin
                        row_q <= row_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_writeback.sv
// Self-checking bench for acc_writeback: ACC FIFO model, GLB write scoreboard,
// table-driven drains plus hand-written reset/ReLU corner cases.
module tb_acc_writeback;

    localparam int PE = 4;
    localparam int DW = 32;
    localparam int RW = PE * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    base_addr;
    logic [PE-1:0] rden;
    logic [RW-1:0] psum_row = '0;
    logic          glb_wren;
    logic          glb_ready;
    logic [7:0]    glb_addr;
    logic [RW-1:0] glb_data;
    logic          busy;
    logic          done;

    acc_writeback dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .rden_o      (rden),
        .psum_row_i  (psum_row),
        .glb_wren_o  (glb_wren),
        .glb_ready_i (glb_ready),
        .glb_addr_o  (glb_addr),
        .glb_data_o  (glb_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    addr;
        logic [RW-1:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] base;
        int         stall_row;
        int         stall_len;
        bit         inject;
        bit         special;
        int         exp_cycles;
        logic [7:0] exp_last;
    } vec_t;

    int            total = 0;
    int            bad   = 0;
    exp_t          q[$];
    logic [RW-1:0] fifo_rows [4];
    int            pops = 0;
    int            pops_at_start = 0;
    logic [7:0]    exp_base = '0;
    logic [7:0]    last_addr = '0;
    logic [RW-1:0] last_data = '0;

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] relu(input logic [RW-1:0] r);
        logic [RW-1:0] o;
        o = r;
`ifdef ACC_WB_RELU_EN
        for (int l = 0; l < PE; l++) begin
            if (r[l*DW + DW - 1]) o[l*DW +: DW] = '0;
        end
`endif
        return o;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] a, input logic [RW-1:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // ACC FIFO model: data appears one cycle after a pop; expected write queued per pop.
    always @(posedge clk) begin
        if (rst_n && rden != '0) begin
            check("rden_lanes", RW'(rden), RW'(4'hF));
            psum_row <= fifo_rows[(pops - pops_at_start) % 4];
            q.push_back(make_exp(exp_base + 8'(pops - pops_at_start),
                                 relu(fifo_rows[(pops - pops_at_start) % 4])));
            pops <= pops + 1;
        end
    end

    // GLB monitor: every cycle with wren high must present the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else if (glb_wren) begin
            if (q.size() == 0) begin
                check("wr_unexpected", RW'(1), RW'(0));
            end else begin
                check("wr_addr", RW'(glb_addr), RW'(q[0].addr));
                check("wr_data", glb_data, q[0].data);
                if (glb_ready) begin
                    last_addr <= glb_addr;
                    last_data <= glb_data;
                    void'(q.pop_front());
                end
            end
        end
    end

    task automatic fill_rows(input logic [7:0] b, input bit special);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < PE; j++) begin
                fifo_rows[k][j*DW +: DW] = (32'(b) << 16) + 32'(52 + k - j);
            end
        end
        if (special) fifo_rows[3] = {32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0};
    endtask

    task automatic run_drain(input vec_t v);
        int n;
        int stall_cnt;
        int p0;
        logic [RW-1:0] exp_special;
        exp_base      = v.base;
        pops_at_start = pops;
        p0            = pops;
        fill_rows(v.base, v.special);
        base_addr = v.base;
        glb_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        n         = 1;
        stall_cnt = 0;
        while (!done && n < 100) begin
            if (v.inject && n == 1) start = 1'b1;
            glb_ready = 1'b1;
            if (glb_wren && (pops - p0) == v.stall_row + 1 && stall_cnt < v.stall_len) begin
                glb_ready = 1'b0;
                stall_cnt++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("done_latency", RW'(n), RW'(v.exp_cycles));
        if (v.inject) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_pulse_width", RW'(done), RW'(0));
        check("idle_after_done", RW'(busy), RW'(0));
        if (v.inject) begin
            repeat (15) @(posedge clk);
            #1;
            check("no_second_drain", RW'(busy), RW'(0));
        end
        check("pop_count", RW'(pops - p0), RW'(4));
        check("last_addr", RW'(last_addr), RW'(v.exp_last));
        check("sb_empty", RW'(q.size()), RW'(0));
        if (v.special) begin
`ifdef ACC_WB_RELU_EN
            exp_special = {32'h0000_0001, 32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000};
`else
            exp_special = {32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0};
`endif
            check("relu_lanes", last_data, exp_special);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rden"}, RW'(rden), RW'(0));
        check({tag, "_wren"}, RW'(glb_wren), RW'(0));
        check({tag, "_addr"}, RW'(glb_addr), RW'(0));
        check({tag, "_data"}, glb_data, RW'(0));
        check({tag, "_busy"}, RW'(busy), RW'(0));
        check({tag, "_done"}, RW'(done), RW'(0));
    endtask

    initial begin
        vec_t vecs[6];
        int   p0;
        int   n;
        vecs[0] = '{8'h10, -1, 0, 1'b0, 1'b0, 13, 8'h13};
        vecs[1] = '{8'h40,  1, 5, 1'b0, 1'b0, 18, 8'h43};
        vecs[2] = '{8'hFE, -1, 0, 1'b0, 1'b0, 13, 8'h01};
        vecs[3] = '{8'h60, -1, 0, 1'b1, 1'b0, 13, 8'h63};
        vecs[4] = '{8'h80,  3, 2, 1'b0, 1'b1, 15, 8'h83};
        vecs[5] = '{8'h20, -1, 0, 1'b0, 1'b0, 13, 8'h23};

        rst_n     = 1'b0;
        start     = 1'b0;
        glb_ready = 1'b1;
        base_addr = '0;
        @(posedge clk); #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_drain(vecs[i]);

        // Reset while row 2 is waiting in WRITE, then a fresh drain must work.
        exp_base      = 8'h50;
        pops_at_start = pops;
        p0            = pops;
        fill_rows(8'h50, 1'b0);
        base_addr = 8'h50;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n     = 0;
        while (!(glb_wren && (pops - p0) == 3) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_row2_write", RW'(n < 50), RW'(1));
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        @(posedge clk); #1;
        check_outputs_zero("rst_edge");
        check("rst_no_pop", RW'(pops - p0), RW'(3));
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_drain(vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
